// File: rtl/booth_mac_pkg.sv
// rtl/booth_mac_pkg.sv - shared types, defaults and clamp helpers for the Booth MAC accumulator
package booth_mac_pkg;

    localparam int DEFAULT_ACC_W   = 24;
    localparam int DEFAULT_MAX_LEN = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Largest signed value representable in `width` bits.
    function automatic logic signed [63:0] clamp_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in `width` bits.
    function automatic logic signed [63:0] clamp_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/booth_mac_accum_if.sv
// rtl/booth_mac_accum_if.sv - product input and frame result handshakes
interface booth_mac_accum_if
    import booth_mac_pkg::*;
#(
    parameter int ACC_W   = DEFAULT_ACC_W,
    parameter int MAX_LEN = DEFAULT_MAX_LEN
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    logic signed [15:0]      prod_in;
    logic                    prod_valid;
    logic                    prod_last;
    logic                    prod_ready;
    logic signed [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0]        acc_count;
    logic                    acc_ovf;
    logic                    acc_trunc;
    logic                    acc_valid;
    logic                    acc_ready;

    modport master (
        output prod_in, prod_valid, prod_last, acc_ready,
        input  prod_ready, acc_out, acc_count, acc_ovf, acc_trunc, acc_valid
    );

    modport slave (
        input  prod_in, prod_valid, prod_last, acc_ready,
        output prod_ready, acc_out, acc_count, acc_ovf, acc_trunc, acc_valid
    );

endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed ACC_W adder with selectable clamp or wrap and overflow flag
module sat_add
    import booth_mac_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W,
    parameter bit SAT   = 1'b1
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(clamp_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(clamp_min(ACC_W));

    logic signed [ACC_W:0] wide;

    // One guard bit: overflow shows as the top two bits disagreeing; the top bit gives the direction.
    always_comb begin
        wide = (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        sum  = wide[ACC_W-1:0];
        if (ovf && SAT) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// rtl/booth_mac_accum.sv - framed signed accumulator for Booth multiplier products
module booth_mac_accum
    import booth_mac_pkg::*;
#(
    parameter int ACC_W   = DEFAULT_ACC_W,
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter bit SAT     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    booth_mac_accum_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] add_a;
    logic signed [ACC_W-1:0] add_b;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    ovf;
    logic                    ovf_next;
    logic                    trunc;
    logic                    trunc_next;
    logic                    prod_xfer;
    logic                    res_xfer;
    logic                    open_new;

    // In HOLD a product may only enter when the held result leaves in the same cycle.
    assign bus.prod_ready = (state != ST_HOLD) || bus.acc_ready;
    assign prod_xfer      = bus.prod_valid && bus.prod_ready;
    assign res_xfer       = (state == ST_HOLD) && bus.acc_ready;
    assign open_new       = prod_xfer && (state != ST_ACCUM);

    // A new frame starts from zero so the first term loads rather than accumulates.
    assign add_a   = open_new ? '0 : acc;
    assign add_b   = {{(ACC_W - 16){bus.prod_in[15]}}, bus.prod_in};
    assign cnt_inc = open_new ? CNT_W'(1) : cnt + CNT_W'(1);

    sat_add #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_sat_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state and next-datapath values for the frame FSM.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        trunc_next = trunc;
        if (prod_xfer) begin
            acc_next = add_sum;
            cnt_next = cnt_inc;
            ovf_next = (!open_new && ovf) || add_ovf;
            if (bus.prod_last || (cnt_inc == CNT_MAX)) begin
                state_next = ST_HOLD;
                trunc_next = !bus.prod_last;
            end else begin
                state_next = ST_ACCUM;
                trunc_next = 1'b0;
            end
        end else if (res_xfer) begin
            state_next = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, term counter and sticky flags; these double as the result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            trunc <= 1'b0;
        end else begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            trunc <= trunc_next;
        end
    end

    assign bus.acc_out   = acc;
    assign bus.acc_count = cnt;
    assign bus.acc_ovf   = ovf;
    assign bus.acc_trunc = trunc;
    assign bus.acc_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_booth_mac_accum.sv
// tb/tb_booth_mac_accum.sv - self-checking bench for booth_mac_accum
module tb_booth_mac_accum;

    localparam int NI = 4;
    localparam int W_TAB  [NI] = '{24, 17, 17, 20};
    localparam int ML_TAB [NI] = '{256, 4, 4, 1};
    localparam bit SAT_TAB[NI] = '{1'b1, 1'b1, 1'b0, 1'b0};

    logic clock;
    logic reset;

    logic signed [15:0] d_in    [NI];
    logic               d_valid [NI];
    logic               d_last  [NI];
    logic               d_ready [NI];

    logic signed [63:0] o_acc    [NI];
    logic [31:0]        o_cnt    [NI];
    logic               o_ovf    [NI];
    logic               o_trunc  [NI];
    logic               o_valid  [NI];
    logic               o_pready [NI];

    int checks = 0;
    int errors = 0;

    longint m_sum  [NI];
    int     m_cnt  [NI];
    bit     m_ovf  [NI];
    bit     m_open [NI];
    bit     m_hold [NI];
    longint r_sum  [NI];
    int     r_cnt  [NI];
    bit     r_ovf  [NI];
    bit     r_trunc[NI];
    bit     pend   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GW  = W_TAB[g];
        localparam int GML = ML_TAB[g];
        localparam bit GS  = SAT_TAB[g];

        booth_mac_accum_if #(.ACC_W(GW), .MAX_LEN(GML)) bus ();

        booth_mac_accum #(.ACC_W(GW), .MAX_LEN(GML), .SAT(GS)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.prod_in    = d_in[g];
        assign bus.prod_valid = d_valid[g];
        assign bus.prod_last  = d_last[g];
        assign bus.acc_ready  = d_ready[g];
        assign o_acc[g]       = 64'(bus.acc_out);
        assign o_cnt[g]       = 32'(bus.acc_count);
        assign o_ovf[g]       = bus.acc_ovf;
        assign o_trunc[g]     = bus.acc_trunc;
        assign o_valid[g]     = bus.acc_valid;
        assign o_pready[g]    = bus.prod_ready;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int k, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_open[k] = 0; m_hold[k] = 0;
            r_sum[k] = 0; r_cnt[k] = 0; r_ovf[k] = 0; r_trunc[k] = 0; pend[k] = 0;
        end
    endtask

    // Reference: frame sum with plain integer arithmetic, clamped or wrapped into ACC_W bits.
    task automatic model_accept(input int k, input longint p, input bit last);
        longint hi;
        longint lo;
        longint s;
        hi = (longint'(1) << (W_TAB[k] - 1)) - 1;
        lo = -hi - 1;
        if (!m_open[k]) begin
            m_sum[k] = p; m_cnt[k] = 1; m_ovf[k] = 0; m_open[k] = 1;
        end else begin
            s = m_sum[k] + p;
            if (s > hi) begin
                m_ovf[k] = 1;
                s = SAT_TAB[k] ? hi : s - 2 * (hi + 1);
            end else if (s < lo) begin
                m_ovf[k] = 1;
                s = SAT_TAB[k] ? lo : s + 2 * (hi + 1);
            end
            m_sum[k] = s;
            m_cnt[k] = m_cnt[k] + 1;
        end
        if (last || m_cnt[k] == ML_TAB[k]) begin
            r_sum[k] = m_sum[k]; r_cnt[k] = m_cnt[k]; r_ovf[k] = m_ovf[k];
            r_trunc[k] = !last; m_hold[k] = 1; m_open[k] = 0;
        end
    endtask

    task automatic check_outs();
        for (int k = 0; k < NI; k++) begin
            chk("acc_valid", k, o_valid[k], m_hold[k]);
            if (m_hold[k]) begin
                chk("acc_out", k, o_acc[k], r_sum[k]);
                chk("acc_count", k, o_cnt[k], r_cnt[k]);
                chk("acc_ovf", k, o_ovf[k], r_ovf[k]);
                chk("acc_trunc", k, o_trunc[k], r_trunc[k]);
            end
        end
    endtask

    // One clock: check ready, let the edge happen, advance the model, check registered outputs.
    task automatic step();
        bit ai[NI];
        bit ro[NI];
        bit er;
        #1;
        for (int k = 0; k < NI; k++) begin
            er = !m_hold[k] || d_ready[k];
            chk("prod_ready", k, o_pready[k], er);
            ai[k]   = d_valid[k] && er;
            ro[k]   = m_hold[k] && d_ready[k];
            pend[k] = d_valid[k] && !er;
        end
        @(posedge clock);
        for (int k = 0; k < NI; k++) begin
            if (ro[k]) m_hold[k] = 0;
            if (ai[k]) model_accept(k, longint'(d_in[k]), d_last[k]);
        end
        @(negedge clock);
        check_outs();
    endtask

    task automatic put(input int k, input int v, input bit last);
        d_in[k] = 16'(v); d_valid[k] = 1'b1; d_last[k] = last;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            d_valid[k] = 1'b0; d_last[k] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            d_in[k] = '0; d_valid[k] = 1'b0; d_last[k] = 1'b0; d_ready[k] = 1'b1;
        end
        model_clear();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_acc_out", k, o_acc[k], 0);
            chk("rst_acc_count", k, o_cnt[k], 0);
            chk("rst_acc_ovf", k, o_ovf[k], 0);
            chk("rst_acc_trunc", k, o_trunc[k], 0);
            chk("rst_acc_valid", k, o_valid[k], 0);
            chk("rst_prod_ready", k, o_pready[k], 1);
        end
        @(negedge clock);

        // Three-term frame.
        put(0, 100, 0);  step();
        put(0, -50, 0);  step();
        put(0, 25, 1);   step();
        chk("t1_sum", 0, o_acc[0], 75);
        chk("t1_count", 0, o_cnt[0], 3);
        chk("t1_ovf", 0, o_ovf[0], 0);
        chk("t1_trunc", 0, o_trunc[0], 0);
        idle_all();      step();
        chk("t1_one_cycle", 0, o_valid[0], 0);

        // Most negative product as a single-term frame.
        put(0, -32768, 1); step();
        chk("t2_sum", 0, o_acc[0], -32768);
        chk("t2_count", 0, o_cnt[0], 1);
        idle_all();        step();

        // Saturation and wrap at ACC_W=17.
        for (int i = 0; i < 3; i++) begin
            put(1, 32767, i == 2);
            put(2, 32767, i == 2);
            step();
        end
        chk("t3_sat_sum", 1, o_acc[1], 65535);
        chk("t3_sat_ovf", 1, o_ovf[1], 1);
        chk("t3_wrap_sum", 2, o_acc[2], -32771);
        chk("t3_wrap_ovf", 2, o_ovf[2], 1);
        idle_all();        step();

        // MAX_LEN=4 force-close, then the remainder continues as a new frame.
        for (int i = 1; i <= 6; i++) begin
            put(1, 1000 * i, 0);
            step();
            if (i == 4) begin
                chk("t4_count", 1, o_cnt[1], 4);
                chk("t4_trunc", 1, o_trunc[1], 1);
                chk("t4_sum", 1, o_acc[1], 10000);
            end
        end
        put(1, 7000, 1);   step();
        chk("t4_next_count", 1, o_cnt[1], 3);
        chk("t4_next_sum", 1, o_acc[1], 18000);
        chk("t4_next_trunc", 1, o_trunc[1], 0);
        idle_all();        step();

        // Back-pressure in HOLD, then simultaneous result and product transfer.
        put(0, 5, 1);      step();
        d_ready[0] = 1'b0;
        put(0, 9, 0);
        repeat (5) step();
        chk("t5_blocked", 0, o_pready[0], 0);
        chk("t5_held_sum", 0, o_acc[0], 5);
        d_ready[0] = 1'b1; step();
        put(0, 10, 1);     step();
        chk("t5_next_sum", 0, o_acc[0], 19);
        chk("t5_next_count", 0, o_cnt[0], 2);
        idle_all();        step();

        // Asynchronous reset mid-frame discards the partial frame.
        put(0, 1, 0);      step();
        put(0, 2, 0);      step();
        idle_all();
        reset = 1'b1;
        #1;
        model_clear();
        for (int k = 0; k < NI; k++) begin
            chk("t6_acc_out", k, o_acc[k], 0);
            chk("t6_acc_count", k, o_cnt[k], 0);
            chk("t6_acc_valid", k, o_valid[k], 0);
        end
        @(negedge clock);
        reset = 1'b0;
        put(0, 7, 0);      step();
        put(0, 8, 1);      step();
        chk("t6_sum", 0, o_acc[0], 15);
        chk("t6_count", 0, o_cnt[0], 2);
        idle_all();        step();

        // Randomized traffic on every configuration, respecting hold-while-stalled.
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NI; k++) begin
                if (!pend[k]) begin
                    d_valid[k] = ($urandom_range(0, 3) != 0);
                    d_in[k]    = 16'($urandom);
                    d_last[k]  = ($urandom_range(0, 4) == 0);
                end
                d_ready[k] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mac_accum.md
# booth_mac_accum

Signed accumulate stage downstream of the radix-4 Booth multiplier. It consumes the multiplier's registered 16-bit two's-complement products through a valid/ready handshake and sums them into a wide accumulator over a frame delimited by `prod_last`. It then presents the frame result (sum, term count, status flags) on an output handshake. Typical use is dot products and FIR taps.

## Interface
- `ACC_W`, 24: accumulator/result width in bits; legal range 17..40.
- `MAX_LEN`, 256: maximum terms per frame; a frame is force-closed at this count.
- `SAT`, 1: 1 = saturating accumulation; 0 = two's-complement wrap.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `prod_in`  in  16  signed product from the multiplier.
- `prod_valid`  in  1  `prod_in` is valid this cycle.
- `prod_last`  in  1  qualifies `prod_valid`; this is the final term of the frame.
- `prod_ready`  out  1  block accepts a product this cycle.
- `acc_out`  out  ACC_W  signed frame sum.
- `acc_count`  out  $clog2(MAX_LEN+1)  number of terms in the frame.
- `acc_ovf`  out  1  saturation or wrap occurred at least once in the frame.
- `acc_trunc`  out  1  frame was closed by the MAX_LEN limit, not by `prod_last`.
- `acc_valid`  out  1  result fields are valid.
- `acc_ready`  in  1  downstream accepts the result.

## Operation
- A product transfer occurs when `prod_valid && prod_ready`. A result transfer occurs when `acc_valid && acc_ready`.
- `prod_in` is sign-extended to ACC_W before it is added.
- FSM states:
  - IDLE: no frame open.
  - ACCUM: frame open.
  - HOLD: result presented.
- IDLE transitions:
  - A transfer loads acc = sext(prod_in) and cnt = 1, and clears ovf.
  - Go to HOLD if `prod_last`, otherwise go to ACCUM.
- ACCUM transitions:
  - A transfer sets acc = acc + sext(prod_in) and cnt = cnt + 1.
  - Go to HOLD if `prod_last` or the new cnt == MAX_LEN. `trunc` = (cnt == MAX_LEN) && !`prod_last`.
  - Without a transfer, the state holds.
- HOLD behaviour:
  - `acc_valid` = 1. All result fields stay stable until the result transfer.
  - On a result transfer with no simultaneous product transfer, go to IDLE.
- `prod_ready` is 1 in IDLE and ACCUM. In HOLD, `prod_ready` = `acc_ready`.
- Simultaneous result and product transfer in HOLD:
  - The product opens a new frame exactly as it would from IDLE.
  - The next state is ACCUM, or HOLD if `prod_last`. This gives zero-bubble back-to-back frames.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - If it exceeds the signed ACC_W range: with SAT=1, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1); with SAT=0, keep the low ACC_W bits.
  - In either case, set ovf. ovf is sticky for the rest of the frame.
- `prod_last` is ignored when `prod_valid` is 0.
- A MAX_LEN=1 configuration closes every frame on its first term. `trunc` is set only if `prod_last` is 0.

## Timing
- Reset values: state IDLE, `acc_out` 0, `acc_count` 0, `acc_ovf` 0, `acc_trunc` 0, `acc_valid` 0. `prod_ready` is 1 once reset deasserts.
- Latency: `acc_valid` rises in the cycle after the clock edge that accepted the closing product.
- Throughput: one product per cycle. A new frame can start in the same cycle the previous result is consumed.
- Reset asserted mid-frame or in HOLD discards the partial or held result immediately. No result is emitted.
- All outputs are registered; there is no combinational path from `prod_*` to `acc_*`. `prod_ready` depends combinationally on `acc_ready` in HOLD only.
- Upstream must hold `prod_in`, `prod_valid` and `prod_last` stable while `prod_valid && !prod_ready`.

## Structure
- Shared package `booth_mac_pkg` holds:
  - the FSM state enum (IDLE, ACCUM, HOLD);
  - the default ACC_W and MAX_LEN;
  - the function for the signed max/min clamp constants.
- Sub-module `sat_add` contains the ACC_W signed adder with SAT-selectable clamp and an overflow output. It is purely combinational and is instantiated once.
- Counter, FSM and output registers live in the top module.

## Test plan
- Frame of products 100, -50, 25 (last on 25), `acc_ready`=1 → `acc_out`=75, `acc_count`=3, `acc_ovf`=0, `acc_trunc`=0, valid for one cycle, one cycle after the last accept.
- Single term -32768 with last, ACC_W=24 → `acc_out`=24'hFF8000, `acc_count`=1.
- ACC_W=17, SAT=1, terms 32767 ×3 → `acc_out`=65535, `acc_ovf`=1. The same run with SAT=0 → `acc_out`=98301 mod 2^17 as signed = -32771, `acc_ovf`=1.
- MAX_LEN=4, six products with no last → first result has `acc_count`=4 and `acc_trunc`=1. The remaining two products form a new frame.
- Result held with `acc_ready`=0 for 5 cycles while `prod_valid`=1 → `prod_ready`=0 and `acc_*` stable. When `acc_ready` rises, the result and the new first product transfer in the same cycle, and the next frame sum starts from that product.
- `reset` pulsed mid-frame after 2 of 3 terms → all outputs return to zero values. The next frame 7, 8 (last) yields 15 and count 2.
